game_period: RTL and testbench
==============================

GAME_PERIOD -- requirements
Module: game_period

Interface
REQ-001 Parameter GAME_SECONDS, default 60, game length in seconds; legal range 1..99.
REQ-002 Clk100M  input  1  system clock; all logic on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 Clk1Hz  input  1  slow timebase level from the divider; only its rising edges are used.
REQ-005 gameSig  input  1  start-game request from the preliminary-period stage; only its rising edges are used.
REQ-006 hitSig  input  1  debounced player scoring input; only its rising edges are used.
REQ-007 doneSig  output  1  one-cycle pulse when the game period ends.
REQ-008 score  output  8  binary score, 0..99.
REQ-009 gameSeg3, gameSeg2  output  8 each  seconds remaining, tens and units; active-low {dp,g,f,e,d,c,b,a}.
REQ-010 gameSeg1, gameSeg0  output  8 each  score, tens and units; same encoding as REQ-009.

Function
REQ-011 Edge detection SHALL register each of Clk1Hz, gameSig and hitSig once and flag a rising edge when the current value is 1 and the registered value is 0.
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 IDLE -> RUN on a gameSig edge; on that edge remaining is loaded with GAME_SECONDS and score is cleared to 0.
REQ-014 In RUN, each Clk1Hz edge SHALL decrement remaining by 1.
REQ-015 In RUN, a Clk1Hz edge while remaining==1 SHALL set remaining to 0, move the FSM to DONE and register doneSig=1; doneSig is therefore high for exactly the next cycle.
REQ-016 In RUN, each hitSig edge SHALL increment score by 1, saturating at 99 with no wrap.
REQ-017 A hitSig edge in the same cycle as the final Clk1Hz edge SHALL still be counted.
REQ-018 hitSig edges in IDLE or DONE SHALL be ignored.
REQ-019 gameSig edges in RUN SHALL be ignored; there is no restart mid-game.
REQ-020 DONE SHALL hold score and remaining=0 on all outputs.
REQ-021 DONE -> RUN on a gameSig edge, with the same load and clear as REQ-013.
REQ-022 doneSig SHALL never be asserted for two consecutive cycles.
REQ-023 In IDLE, all four gameSeg outputs SHALL be 8'b11111111 (blank).
REQ-024 In RUN and DONE, the gameSeg outputs SHALL show decimal digits; a leading zero is displayed, not blanked.
REQ-025 The gameSeg outputs SHALL be registered and update one cycle after the value they display changes.
REQ-026 Digit codes, with dp always off:
- 0=11000000, 1=11111001, 2=10100100, 3=10110000, 4=10011001
- 5=10010010, 6=10000010, 7=11111000, 8=10000000, 9=10010000

Reset
REQ-027 rst SHALL force, on the next clock edge: state=IDLE, remaining=0, score=0, doneSig=0, all gameSeg=8'hFF.
REQ-028 rst SHALL load all three edge-detector registers with 1, so an input held high through reset produces no edge.
REQ-029 rst SHALL take priority over every other event, including in mid-RUN.

Verification (GAME_SECONDS=3 for the bench)
REQ-030 Reset, then idle 10 cycles -> all gameSeg=8'hFF, score=0, doneSig=0.
REQ-031 One gameSig edge, then 3 Clk1Hz edges ->
- gameSeg3/2 step through 0/3, 0/2, 0/1, 0/0.
- doneSig high for exactly 1 cycle after the third edge.
- State stays DONE afterwards.
REQ-032 5 hitSig edges during RUN, plus 1 hitSig edge coincident with the final Clk1Hz edge ->
- score=6.
- gameSeg1=11000000, gameSeg0=10000010.
- Score unchanged by further hitSig edges in DONE.
REQ-033 105 hitSig edges during RUN (GAME_SECONDS=99 for this scenario) -> score saturates at 99; gameSeg1 and gameSeg0 both 10010000.
REQ-034 gameSig edge during RUN -> no reload; countdown continues. Then gameSig edge in DONE -> remaining=3, score=0, state RUN.
REQ-035 rst asserted mid-RUN with gameSig and Clk1Hz held high -> IDLE with all outputs at reset values; no spurious start once rst deasserts.

Source files
------------

// File: rtl/game_period.sv
// game_period: timed game stage counting seconds down and player hits up,
// driving a 4-digit seven-segment view of time remaining and score.
module game_period #(
    parameter int GAME_SECONDS = 60
) (
    input  logic       Clk100M,
    input  logic       rst,
    input  logic       Clk1Hz,
    input  logic       gameSig,
    input  logic       hitSig,
    output logic       doneSig,
    output logic [7:0] score,
    output logic [7:0] gameSeg3,
    output logic [7:0] gameSeg2,
    output logic [7:0] gameSeg1,
    output logic [7:0] gameSeg0
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic        sec_q, game_q, hit_q;
    logic        sec_e, game_e, hit_e;
    logic [7:0]  rem_q, rem_d;
    logic [7:0]  score_q, score_d;
    logic        done_q, done_d;
    logic [31:0] seg_q, seg_d;

    function automatic logic [7:0] seg7(input logic [7:0] d);
        case (d)
            8'd0:    return 8'hC0;
            8'd1:    return 8'hF9;
            8'd2:    return 8'hA4;
            8'd3:    return 8'hB0;
            8'd4:    return 8'h99;
            8'd5:    return 8'h92;
            8'd6:    return 8'h82;
            8'd7:    return 8'hF8;
            8'd8:    return 8'h80;
            8'd9:    return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    assign sec_e  = Clk1Hz & ~sec_q;
    assign game_e = gameSig & ~game_q;
    assign hit_e  = hitSig & ~hit_q;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        score_d = score_q;
        done_d  = 1'b0;
        if (state_q == RUN) begin
            if (sec_e) begin
                rem_d   = rem_q - 8'd1;
                state_d = (rem_q == 8'd1) ? DONE : RUN;
                done_d  = (rem_q == 8'd1);
            end
            if (hit_e && score_q < 8'd99)
                score_d = score_q + 8'd1;
        end else if (game_e) begin
            state_d = RUN;
            rem_d   = 8'(GAME_SECONDS);
            score_d = 8'd0;
        end
    end

    // Display follows the registered counters, so it trails them by one cycle.
    always_comb begin
        seg_d = (state_q == IDLE) ? 32'hFFFF_FFFF :
                {seg7(rem_q / 8'd10), seg7(rem_q % 8'd10),
                 seg7(score_q / 8'd10), seg7(score_q % 8'd10)};
    end

    always_ff @(posedge Clk100M) begin
        if (rst) begin
            state_q <= IDLE;
            sec_q   <= 1'b1;
            game_q  <= 1'b1;
            hit_q   <= 1'b1;
            rem_q   <= 8'd0;
            score_q <= 8'd0;
            done_q  <= 1'b0;
            seg_q   <= 32'hFFFF_FFFF;
        end else begin
            state_q <= state_d;
            sec_q   <= Clk1Hz;
            game_q  <= gameSig;
            hit_q   <= hitSig;
            rem_q   <= rem_d;
            score_q <= score_d;
            done_q  <= done_d;
            seg_q   <= seg_d;
        end
    end

    assign doneSig  = done_q;
    assign score    = score_q;
    assign gameSeg3 = seg_q[31:24];
    assign gameSeg2 = seg_q[23:16];
    assign gameSeg1 = seg_q[15:8];
    assign gameSeg0 = seg_q[7:0];
endmodule

// File: tb/tb_game_period.sv
// tb_game_period: directed checks of a 3-second game instance, with a
// 99-second instance on the same inputs for score saturation.
module tb_game_period;
    localparam logic [7:0] S0 = 8'hC0, S1 = 8'hF9, S2 = 8'hA4, S3 = 8'hB0;
    localparam logic [7:0] S6 = 8'h82, S9 = 8'h90, BL = 8'hFF;

    logic       clk = 0, rst = 1, sec = 0, game = 0, hit = 0;
    logic       done_a, done_b;
    logic [7:0] score_a, score_b;
    logic [7:0] a3, a2, a1, a0, b3, b2, b1, b0;
    int         checks = 0, failures = 0;
    logic       done_prev = 0;

    game_period #(.GAME_SECONDS(3)) dut_a (
        .Clk100M(clk), .rst(rst), .Clk1Hz(sec), .gameSig(game), .hitSig(hit),
        .doneSig(done_a), .score(score_a),
        .gameSeg3(a3), .gameSeg2(a2), .gameSeg1(a1), .gameSeg0(a0)
    );

    game_period #(.GAME_SECONDS(99)) dut_b (
        .Clk100M(clk), .rst(rst), .Clk1Hz(sec), .gameSig(game), .hitSig(hit),
        .doneSig(done_b), .score(score_b),
        .gameSeg3(b3), .gameSeg2(b2), .gameSeg1(b1), .gameSeg0(b0)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done_a && done_prev) begin
            failures++;
            $display("FAIL done_twice got=11 exp=not two consecutive highs");
        end
        done_prev <= done_a;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_game();
        game = 1; step(); game = 0; step();
    endtask

    task automatic pulse_hit();
        hit = 1; step(); hit = 0; step();
    endtask

    task automatic pulse_sec();
        sec = 1; step(); sec = 0; step();
    endtask

    task automatic test_reset();
        rst = 1; step(2); rst = 0; step(10);
        checks++; if ({a3, a2, a1, a0} !== {4{BL}}) begin failures++; $display("FAIL reset_seg got=%h exp=%h", {a3, a2, a1, a0}, {4{BL}}); end
        checks++; if (score_a !== 8'd0) begin failures++; $display("FAIL reset_score got=%0d exp=0", score_a); end
        checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done_a); end
    endtask

    task automatic test_countdown_score();
        pulse_game();
        checks++; if ({a3, a2} !== {S0, S3}) begin failures++; $display("FAIL start_time got=%h exp=%h", {a3, a2}, {S0, S3}); end
        repeat (5) pulse_hit();
        checks++; if (score_a !== 8'd5) begin failures++; $display("FAIL hits5 got=%0d exp=5", score_a); end
        pulse_sec();
        checks++; if ({a3, a2} !== {S0, S2}) begin failures++; $display("FAIL time2 got=%h exp=%h", {a3, a2}, {S0, S2}); end
        pulse_sec();
        checks++; if ({a3, a2, done_a} !== {S0, S1, 1'b0}) begin failures++; $display("FAIL time1 got=%h exp=%h", {a3, a2, done_a}, {S0, S1, 1'b0}); end
        sec = 1; hit = 1; step();
        checks++; if (done_a !== 1'b1) begin failures++; $display("FAIL done_pulse got=%b exp=1", done_a); end
        sec = 0; hit = 0; step();
        checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL done_fall got=%b exp=0", done_a); end
        checks++; if ({a3, a2} !== {S0, S0}) begin failures++; $display("FAIL time0 got=%h exp=%h", {a3, a2}, {S0, S0}); end
        checks++; if (score_a !== 8'd6) begin failures++; $display("FAIL final_hit got=%0d exp=6", score_a); end
        checks++; if ({a1, a0} !== {S0, S6}) begin failures++; $display("FAIL score_seg got=%h exp=%h", {a1, a0}, {S0, S6}); end
        pulse_hit(); pulse_hit(); pulse_sec();
        checks++; if (score_a !== 8'd6) begin failures++; $display("FAIL done_hit got=%0d exp=6", score_a); end
        checks++; if ({a3, a2, a1, a0, done_a} !== {S0, S0, S0, S6, 1'b0}) begin failures++; $display("FAIL done_hold got=%h exp=%h", {a3, a2, a1, a0, done_a}, {S0, S0, S0, S6, 1'b0}); end
    endtask

    task automatic test_restart();
        pulse_game();
        checks++; if ({a3, a2, a1, a0} !== {S0, S3, S0, S0}) begin failures++; $display("FAIL restart got=%h exp=%h", {a3, a2, a1, a0}, {S0, S3, S0, S0}); end
        checks++; if (score_a !== 8'd0) begin failures++; $display("FAIL restart_score got=%0d exp=0", score_a); end
        pulse_sec();
        pulse_game();
        checks++; if ({a3, a2} !== {S0, S2}) begin failures++; $display("FAIL no_reload got=%h exp=%h", {a3, a2}, {S0, S2}); end
        pulse_sec();
        checks++; if ({a3, a2} !== {S0, S1}) begin failures++; $display("FAIL continue got=%h exp=%h", {a3, a2}, {S0, S1}); end
    endtask

    task automatic test_saturation();
        rst = 1; step(2); rst = 0; step(2);
        pulse_game();
        checks++; if ({b3, b2} !== {S9, S9}) begin failures++; $display("FAIL b_start got=%h exp=%h", {b3, b2}, {S9, S9}); end
        repeat (105) pulse_hit();
        checks++; if (score_b !== 8'd99) begin failures++; $display("FAIL sat_score got=%0d exp=99", score_b); end
        checks++; if ({b1, b0} !== {S9, S9}) begin failures++; $display("FAIL sat_seg got=%h exp=%h", {b1, b0}, {S9, S9}); end
    endtask

    task automatic test_reset_midrun();
        sec = 1; game = 1; rst = 1; step(2);
        checks++; if ({a3, a2, a1, a0, score_a, done_a} !== {{4{BL}}, 8'd0, 1'b0}) begin failures++; $display("FAIL midrun_rst got=%h exp=%h", {a3, a2, a1, a0, score_a, done_a}, {{4{BL}}, 8'd0, 1'b0}); end
        rst = 0; step(3);
        checks++; if ({a3, a2, a1, a0} !== {4{BL}}) begin failures++; $display("FAIL no_spurious got=%h exp=%h", {a3, a2, a1, a0}, {4{BL}}); end
        sec = 0; game = 0; step(2);
        pulse_hit();
        checks++; if ({score_a, a3, a2, a1, a0} !== {8'd0, {4{BL}}}) begin failures++; $display("FAIL idle_hit got=%h exp=%h", {score_a, a3, a2, a1, a0}, {8'd0, {4{BL}}}); end
    endtask

    initial begin
        test_reset();
        test_countdown_score();
        test_restart();
        test_saturation();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
